jtag_mem_access_ctrl: RTL

JTAG_MEM_ACCESS_CTRL -- requirements
Module: jtag_mem_access_ctrl

---
 rtl/jtag_mem_access_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/jtag_mem_access_ctrl.sv
// JTAG-driven single-beat memory access controller: turns MEM_READ/MEM_WRITE DR
// updates into one bus transfer with timeout, sticky error flags and capture data.
module jtag_mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [4:0]  cmd_ir,
  input  logic [63:0] cmd_data,
  input  logic        clear_sticky,
  output logic [63:0] cap_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic [3:0]  err_flags
);

  localparam logic [4:0]  IR_READ  = 5'h02;
  localparam logic [4:0]  IR_WRITE = 5'h03;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_COMPLETE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [63:0] cap_q, cap_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  err_set;
  logic        is_mem;

  assign is_mem = cmd_valid && ((cmd_ir == IR_READ) || (cmd_ir == IR_WRITE));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    cap_d       = cap_q;
    err_set     = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          if (cmd_data[1:0] != 2'b00) begin
            err_set[2]   = 1'b1;
            cap_d[31:0]  = cmd_data[31:0];
          end else begin
            state_d     = S_ACCESS;
            bus_req_d   = 1'b1;
            bus_we_d    = (cmd_ir == IR_WRITE);
            bus_addr_d  = cmd_data[31:0];
            bus_wdata_d = cmd_data[63:32];
            cnt_d       = 16'd0;
          end
        end
      end
      S_ACCESS: begin
        if (is_mem) err_set[3] = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (bus_err || bus_ack || (cnt_q == CNT_LAST)) begin
          state_d     = S_COMPLETE;
          bus_req_d   = 1'b0;
          cnt_d       = 16'd0;
          cap_d[31:0] = bus_addr_q;
          // bus_err takes priority over a coincident ack
          if (bus_err) begin
            err_set[1] = 1'b1;
            if (!bus_we_q) cap_d[63:32] = ERR_RDATA;
          end else if (bus_ack) begin
            if (!bus_we_q) cap_d[63:32] = bus_rdata;
          end else begin
            err_set[0] = 1'b1;
            if (!bus_we_q) cap_d[63:32] = ERR_RDATA;
          end
        end
      end
      S_COMPLETE: begin
        if (is_mem) err_set[3] = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a flag raised in the same cycle as clear_sticky survives
    err_d = (clear_sticky ? 4'b0000 : err_q) | err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      cap_q       <= 64'd0;
      err_q       <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      cap_q       <= cap_d;
      err_q       <= err_d;
    end
  end

  assign cap_data  = cap_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign err_flags = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
